vend_fsm_param: RTL and testbench

Parametrised vending controller that accepts 10- and 20-unit coins, accumulates credit up to a configurable ceiling, and vends one of `NUM_ITEMS` products with per-item prices. After a vend or a cancel, it pays change back as a paced train of one-unit pulses. It sits between the coin acceptor and the product dispensers and reports live credit and per-item affordability to the front panel.

---
 rtl/vend_fsm_param.sv | 158 +++++++++++++++
 tb/tb_vend_fsm_param.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/vend_fsm_param.sv
// Vending controller: 10/20 coin credit, per-item prices, paced change.
// Optional idle-credit refund timer under VEND_TIMEOUT_REFUND_EN.
module vend_fsm_param #(
  parameter int NUM_ITEMS = 4,
  parameter int CREDIT_W = 6,
  parameter int MAX_CREDIT = 5,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] ITEM_PRICES =
    {6'd4, 6'd4, 6'd3, 6'd3},
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           coin,
  input  logic                 cancel,
  input  logic [NUM_ITEMS-1:0] choice,
  output logic [NUM_ITEMS-1:0] vend,
  output logic [CREDIT_W-1:0]  credit,
  output logic [NUM_ITEMS-1:0] avail,
  output logic                 change_pulse,
  output logic                 coin_reject,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE,
    CREDIT,
    VEND,
    CHANGE
  } state_t;

  state_t state, state_n;
  logic [CREDIT_W-1:0]  credit_n;
  logic [NUM_ITEMS-1:0] sel, sel_n;
  logic                 reject_n;
  logic [CREDIT_W-1:0]  coin_val;
  logic [CREDIT_W:0]    sum;
  logic                 coin_fits;
  logic                 choice_1h;
  logic                 choice_ok;
  logic                 to_hit;

  if (MAX_CREDIT >= (1 << CREDIT_W) || TIMEOUT_CYCLES < 2)
  begin : g_bad_cfg
    $error("vend_fsm_param: bad parameters");
  end

  function automatic logic [CREDIT_W-1:0] price_of(
    input logic [NUM_ITEMS-1:0] oh
  );
    price_of = '0;
    for (int i = 0; i < NUM_ITEMS; i++)
      if (oh[i])
        price_of |= ITEM_PRICES[i*CREDIT_W +: CREDIT_W];
  endfunction

  always_comb begin
    coin_val = '0;
    if (coin == 2'b01) coin_val = CREDIT_W'(1);
    if (coin == 2'b10) coin_val = CREDIT_W'(2);
  end

  assign sum = {1'b0, credit} + {1'b0, coin_val};
  assign coin_fits = (coin_val != '0) &&
                     (sum <= (CREDIT_W+1)'(MAX_CREDIT));
  assign choice_1h = (choice != '0) &&
                     ((choice & (choice - NUM_ITEMS'(1))) == '0);
  assign choice_ok = choice_1h && (price_of(choice) <= credit);

`ifdef VEND_TIMEOUT_REFUND_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  logic [TO_W-1:0] to_cnt;

  // Held at zero outside CREDIT, so entry to CREDIT starts from zero.
  always_ff @(posedge clock) begin
    if (reset)
      to_cnt <= '0;
    else if (state != CREDIT || coin != 2'b00)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + TO_W'(1);
  end

  assign to_hit = (state == CREDIT) &&
                  (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    credit_n = credit;
    sel_n    = sel;
    reject_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (coin_val != '0) begin
          credit_n = coin_val;
          state_n  = CREDIT;
        end else if (coin == 2'b11) begin
          reject_n = 1'b1;
        end
      end
      CREDIT: begin
        if (cancel) begin
          state_n  = CHANGE;
          reject_n = (coin != 2'b00);
        end else if (choice_ok) begin
          sel_n    = choice;
          state_n  = VEND;
          reject_n = (coin != 2'b00);
        end else if (coin != 2'b00) begin
          if (coin_fits) credit_n = sum[CREDIT_W-1:0];
          else           reject_n = 1'b1;
        end else if (to_hit) begin
          state_n = CHANGE;
        end
      end
      VEND: begin
        credit_n = credit - price_of(sel);
        state_n  = (credit_n != '0) ? CHANGE : IDLE;
        sel_n    = '0;
        reject_n = (coin != 2'b00);
      end
      CHANGE: begin
        credit_n = credit - CREDIT_W'(1);
        if (credit == CREDIT_W'(1)) state_n = IDLE;
        reject_n = (coin != 2'b00);
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      credit      <= '0;
      sel         <= '0;
      coin_reject <= 1'b0;
    end else begin
      state       <= state_n;
      credit      <= credit_n;
      sel         <= sel_n;
      coin_reject <= reject_n;
    end
  end

  always_comb begin
    avail = '0;
    for (int i = 0; i < NUM_ITEMS; i++)
      avail[i] = (state == CREDIT) &&
                 (ITEM_PRICES[i*CREDIT_W +: CREDIT_W] <= credit);
  end

  assign vend         = (state == VEND) ? sel : '0;
  assign change_pulse = (state == CHANGE);
  assign busy         = (state == VEND) || (state == CHANGE);

endmodule

// File: tb/tb_vend_fsm_param.sv
// Directed table-driven bench for vend_fsm_param (default params,
// TIMEOUT_CYCLES = 8 so the refund timer is reachable when enabled).
module tb_vend_fsm_param;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] coin;
  logic       cancel;
  logic [3:0] choice;
  logic [3:0] vend;
  logic [5:0] credit;
  logic [3:0] avail;
  logic       change_pulse;
  logic       coin_reject;
  logic       busy;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  vend_fsm_param #(.TIMEOUT_CYCLES(8)) dut (
    .clock(clock),
    .reset(reset),
    .coin(coin),
    .cancel(cancel),
    .choice(choice),
    .vend(vend),
    .credit(credit),
    .avail(avail),
    .change_pulse(change_pulse),
    .coin_reject(coin_reject),
    .busy(busy)
  );

  typedef struct {
    logic [1:0] coin;
    logic       cancel;
    logic [3:0] choice;
    logic [5:0] credit;
    logic [3:0] avail;
    logic [3:0] vend;
    logic       pulse;
    logic       rej;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(
    input logic [1:0] c, input logic can, input logic [3:0] ch,
    input logic [5:0] cr, input logic [3:0] av, input logic [3:0] vd,
    input logic p, input logic r, input logic b
  );
    vec_t x;
    x.coin = c; x.cancel = can; x.choice = ch;
    x.credit = cr; x.avail = av; x.vend = vd;
    x.pulse = p; x.rej = r; x.busy = b;
    return x;
  endfunction

  task automatic check(
    input string name, input logic [5:0] cr, input logic [3:0] av,
    input logic [3:0] vd, input logic p, input logic r, input logic b
  );
    tests++;
    if ({credit, avail, vend, change_pulse, coin_reject, busy} !==
        {cr, av, vd, p, r, b}) begin
      fails++;
      $display("FAIL %s: got cr=%0d av=%b vd=%b p=%b r=%b b=%b, want cr=%0d av=%b vd=%b p=%b r=%b b=%b",
               name, credit, avail, vend, change_pulse, coin_reject,
               busy, cr, av, vd, p, r, b);
    end
  endtask

  task automatic cyc(
    input logic [1:0] c, input logic can, input logic [3:0] ch
  );
    coin = c; cancel = can; choice = ch;
    @(posedge clock);
    #1;
    coin = 2'b00; cancel = 1'b0; choice = 4'b0000;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bad;
    reset = 1'b1; coin = 2'b00; cancel = 1'b0; choice = 4'b0000;
    repeat (2) @(posedge clock);
    #1;
    check("reset", 6'd0, 4'b0, 4'b0, 0, 0, 0);
    reset = 1'b0;

    // coin 20,20 -> vend item 2 (price 4), no change
    tbl.push_back(v(2'b10, 0, 4'b0000, 2, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(v(2'b10, 0, 4'b0000, 4, 4'b1111, 4'b0000, 0, 0, 0));
    tbl.push_back(v(2'b00, 0, 4'b0100, 4, 4'b0000, 4'b0100, 0, 0, 1));
    tbl.push_back(v(2'b00, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(v(2'b00, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0));
    // credit 5, vend item 0 (price 3), two change pulses
    tbl.push_back(v(2'b10, 0, 4'b0000, 2, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(v(2'b10, 0, 4'b0000, 4, 4'b1111, 4'b0000, 0, 0, 0));
    tbl.push_back(v(2'b01, 0, 4'b0000, 5, 4'b1111, 4'b0000, 0, 0, 0));
    tbl.push_back(v(2'b00, 0, 4'b0001, 5, 4'b0000, 4'b0001, 0, 0, 1));
    tbl.push_back(v(2'b00, 0, 4'b0000, 2, 4'b0000, 4'b0000, 1, 0, 1));
    tbl.push_back(v(2'b00, 0, 4'b0000, 1, 4'b0000, 4'b0000, 1, 0, 1));
    tbl.push_back(v(2'b00, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0));
    // ceiling reject at 5, cancel refunds 5, then 2'b11 in IDLE
    tbl.push_back(v(2'b10, 0, 4'b0000, 2, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(v(2'b10, 0, 4'b0000, 4, 4'b1111, 4'b0000, 0, 0, 0));
    tbl.push_back(v(2'b01, 0, 4'b0000, 5, 4'b1111, 4'b0000, 0, 0, 0));
    tbl.push_back(v(2'b01, 0, 4'b0000, 5, 4'b1111, 4'b0000, 0, 1, 0));
    tbl.push_back(v(2'b00, 0, 4'b0000, 5, 4'b1111, 4'b0000, 0, 0, 0));
    tbl.push_back(v(2'b00, 1, 4'b0000, 5, 4'b0000, 4'b0000, 1, 0, 1));
    tbl.push_back(v(2'b00, 0, 4'b0000, 4, 4'b0000, 4'b0000, 1, 0, 1));
    tbl.push_back(v(2'b00, 0, 4'b0000, 3, 4'b0000, 4'b0000, 1, 0, 1));
    tbl.push_back(v(2'b00, 0, 4'b0000, 2, 4'b0000, 4'b0000, 1, 0, 1));
    tbl.push_back(v(2'b00, 0, 4'b0000, 1, 4'b0000, 4'b0000, 1, 0, 1));
    tbl.push_back(v(2'b00, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(v(2'b11, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 1, 0));
    // credit 3, cancel beats choice, three pulses
    tbl.push_back(v(2'b10, 0, 4'b0000, 2, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(v(2'b01, 0, 4'b0000, 3, 4'b0011, 4'b0000, 0, 0, 0));
    tbl.push_back(v(2'b00, 1, 4'b0001, 3, 4'b0000, 4'b0000, 1, 0, 1));
    tbl.push_back(v(2'b00, 0, 4'b0000, 2, 4'b0000, 4'b0000, 1, 0, 1));
    tbl.push_back(v(2'b00, 0, 4'b0000, 1, 4'b0000, 4'b0000, 1, 0, 1));
    tbl.push_back(v(2'b00, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0));
    // credit 4, non-one-hot choice ignored, cancel+coin rejects coin
    tbl.push_back(v(2'b10, 0, 4'b0000, 2, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(v(2'b10, 0, 4'b0000, 4, 4'b1111, 4'b0000, 0, 0, 0));
    tbl.push_back(v(2'b00, 0, 4'b0011, 4, 4'b1111, 4'b0000, 0, 0, 0));
    tbl.push_back(v(2'b10, 1, 4'b0000, 4, 4'b0000, 4'b0000, 1, 1, 1));
    tbl.push_back(v(2'b00, 0, 4'b0000, 3, 4'b0000, 4'b0000, 1, 0, 1));
    tbl.push_back(v(2'b00, 0, 4'b0000, 2, 4'b0000, 4'b0000, 1, 0, 1));
    tbl.push_back(v(2'b00, 0, 4'b0000, 1, 4'b0000, 4'b0000, 1, 0, 1));
    tbl.push_back(v(2'b00, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0));

    foreach (tbl[i]) begin
      cyc(tbl[i].coin, tbl[i].cancel, tbl[i].choice);
      check($sformatf("row%0d", i), tbl[i].credit, tbl[i].avail,
            tbl[i].vend, tbl[i].pulse, tbl[i].rej, tbl[i].busy);
    end

    // Unaffordable choice, vend with change, coin in CHANGE, reset
    cyc(2'b10, 0, 4'b0000);
    check("seq_c2", 2, 4'b0000, 4'b0000, 0, 0, 0);
    cyc(2'b00, 0, 4'b0100);
    check("seq_poor_choice", 2, 4'b0000, 4'b0000, 0, 0, 0);
    cyc(2'b10, 0, 4'b0000);
    cyc(2'b01, 0, 4'b0000);
    check("seq_c5", 5, 4'b1111, 4'b0000, 0, 0, 0);
    cyc(2'b00, 0, 4'b0001);
    check("seq_vend0", 5, 4'b0000, 4'b0001, 0, 0, 1);
    cyc(2'b00, 0, 4'b0000);
    check("seq_pulse1", 2, 4'b0000, 4'b0000, 1, 0, 1);
    cyc(2'b10, 0, 4'b0000);
    check("seq_change_rej", 1, 4'b0000, 4'b0000, 1, 1, 1);
    reset = 1'b1;
    cyc(2'b00, 0, 4'b0000);
    reset = 1'b0;
    check("seq_mid_reset", 0, 4'b0000, 4'b0000, 0, 0, 0);
    cyc(2'b00, 0, 4'b0000);
    check("seq_after_reset", 0, 4'b0000, 4'b0000, 0, 0, 0);

    // Idle credit: timed refund when enabled, held otherwise
    cyc(2'b01, 0, 4'b0000);
    check("to_c1", 1, 4'b0000, 4'b0000, 0, 0, 0);
`ifdef VEND_TIMEOUT_REFUND_EN
    repeat (7) cyc(2'b00, 0, 4'b0000);
    check("to_wait7", 1, 4'b0000, 4'b0000, 0, 0, 0);
    cyc(2'b00, 0, 4'b0000);
    check("to_change", 1, 4'b0000, 4'b0000, 1, 0, 1);
    cyc(2'b00, 0, 4'b0000);
    check("to_idle", 0, 4'b0000, 4'b0000, 0, 0, 0);
`else
    bad = 0;
    for (int k = 0; k < 120; k++) begin
      cyc(2'b00, 0, 4'b0000);
      if (credit !== 6'd1 || busy !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL hold_credit: %0d bad cycles, want 0", bad);
    end
    cyc(2'b00, 1, 4'b0000);
    check("hold_cancel", 1, 4'b0000, 4'b0000, 1, 0, 1);
    cyc(2'b00, 0, 4'b0000);
    check("hold_idle", 0, 4'b0000, 4'b0000, 0, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
